// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default framing constants and
// a counter-width helper used by both the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_BITS_DEF  = 8;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'b00,
        RX_START = 2'b01,
        RX_DATA  = 2'b10,
        RX_STOP  = 2'b11
    } rx_state_e;

    // Width for a counter over 0..n-1; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 oversampled UART receiver: start-bit validation at mid bit, LSB-first capture,
// held output byte with valid/ack handshake, framing-error and overrun pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic                 rx_serial,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int unsigned TickW = cnt_width(OVERSAMPLE);
    localparam int unsigned BitW  = cnt_width(DATA_BITS);

    localparam logic [TickW-1:0] TickMid = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickEnd = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast = BitW'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_s;
    logic                 capture;
    logic                 stop_bad;

    uart_rx_sync u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (rx_serial),
        .q_o    (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        capture    = 1'b0;
        stop_bad   = 1'b0;
        if (os_tick) begin
            unique case (state_q)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state_d    = RX_START;
                        tick_cnt_d = '0;
                    end
                end
                RX_START: begin
                    if (tick_cnt_q == TickMid) begin
                        // A line that is high again at mid start bit was only a glitch.
                        state_d    = rx_s ? RX_IDLE : RX_DATA;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                RX_DATA: begin
                    if (tick_cnt_q == TickEnd) begin
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        if (bit_cnt_q == BitLast) begin
                            state_d = RX_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BitW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                RX_STOP: begin
                    if (tick_cnt_q == TickEnd) begin
                        // Leave at mid stop bit so a back-to-back start edge is not missed.
                        state_d    = RX_IDLE;
                        tick_cnt_d = '0;
                        capture    = rx_s;
                        stop_bad   = !rx_s;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TickW'(1);
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = stop_bad;
        overrun_d   = 1'b0;
        if (capture) begin
            // Capture beats a same-cycle ack; that ack consumed the old byte, so no overrun.
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q && !rx_ack;
        end else if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_busy   = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized frames against a byte-level reference model of the receiver.
module tb_uart_receiver;

    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    // Ticks from the tick that launches a start bit to the mid-stop sample:
    // one tick to notice the low line, half a bit to mid start, then data bits plus stop.
    localparam int MID_STOP = 1 + OS / 2 + OS * 9;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       os_tick = 1'b0;
    logic       rx_serial = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int checks = 0;
    int fails  = 0;

    // Reference model state.
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    int         exp_ferr  = 0;
    int         exp_ovr   = 0;

    uart_receiver #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .os_tick   (os_tick),
        .rx_serial (rx_serial),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    int div = 0;
    always @(negedge clk) begin
        os_tick = (div == 0);
        div     = (div == TICK_DIV - 1) ? 0 : div + 1;
    end

    int   tick_no   = 0;
    logic tick_seen = 1'b0;
    always @(posedge clk) begin
        tick_seen <= os_tick;
        if (os_tick) tick_no <= tick_no + 1;
    end

    int   ferr_cycles     = 0;
    int   ovr_cycles      = 0;
    int   valid_rise_tick = -1;
    int   ferr_tick       = -1;
    logic valid_prev      = 1'b0;
    always @(negedge clk) begin
        if (frame_err === 1'b1) begin
            ferr_cycles++;
            ferr_tick = tick_seen ? tick_no : -1;
        end
        if (overrun === 1'b1) ovr_cycles++;
        if (rx_valid === 1'b1 && valid_prev !== 1'b1) valid_rise_tick = tick_seen ? tick_no : -1;
        valid_prev = rx_valid;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, expected finish within time limit");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (os_tick !== 1'b1);
        end
        #1;
    endtask

    task automatic align(output int k);
        wait_ticks(1);
        k = tick_no;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        rx_serial = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            wait_ticks(OS);
        end
        rx_serial = stop_ok;
        wait_ticks(OS);
        rx_serial = 1'b1;
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
        if (exp_valid) exp_valid = 1'b0;
    endtask

    function automatic void model_frame(input logic [7:0] b, input logic stop_ok,
                                        input logic ack_now);
        if (stop_ok) begin
            if (exp_valid && !ack_now) exp_ovr++;
            exp_valid = 1'b1;
            exp_data  = b;
        end else begin
            exp_ferr++;
        end
    endfunction

    initial begin
        int         k;
        logic [7:0] b;
        logic       stop_ok;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_ovr", overrun, 0);
        check("reset_busy", rx_busy, 0);
        rst = 1'b1;
        wait_ticks(3);

        // Clean 0xA5
        align(k);
        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1, 1'b0);
        check("a5_data", rx_data, exp_data);
        check("a5_valid", rx_valid, exp_valid);
        check("a5_latency", valid_rise_tick, k + MID_STOP);
        check("a5_ferr", ferr_cycles, exp_ferr);
        check("a5_ovr", ovr_cycles, exp_ovr);
        pulse_ack();
        check("a5_ack_clears", rx_valid, exp_valid);
        pulse_ack();
        check("ack_idle_ignored", rx_valid, 0);
        check("ack_idle_data", rx_data, 8'hA5);

        // Short low glitch in idle
        align(k);
        rx_serial = 1'b0;
        wait_ticks(4);
        rx_serial = 1'b1;
        check("glitch_busy_hi", rx_busy, 1);
        wait_ticks(5);
        check("glitch_busy_lo", rx_busy, 0);
        check("glitch_valid", rx_valid, 0);
        check("glitch_ferr", ferr_cycles, exp_ferr);

        // 0x3C with a low stop bit
        align(k);
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b0);
        wait_ticks(10);
        check("ferr_count", ferr_cycles, exp_ferr);
        check("ferr_latency", ferr_tick, k + MID_STOP);
        check("ferr_valid", rx_valid, exp_valid);
        check("ferr_data_kept", rx_data, 8'hA5);
        check("ferr_busy", rx_busy, 0);

        // Back-to-back 0x11, 0x22 without ack
        align(k);
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1);
        model_frame(8'h22, 1'b1, 1'b0);
        wait_ticks(2);
        check("b2b_ovr", ovr_cycles, exp_ovr);
        check("b2b_data", rx_data, 8'h22);
        check("b2b_valid", rx_valid, 1);

        // Ack landing exactly on the capture of 0x7E
        align(k);
        fork
            send_frame(8'h7E, 1'b1);
            begin
                wait (tick_no == k + MID_STOP - 1);
                do begin
                    @(negedge clk);
                    #1;
                end while (os_tick !== 1'b1);
                rx_ack = 1'b1;
                @(posedge clk);
                #1 rx_ack = 1'b0;
            end
        join
        model_frame(8'h7E, 1'b1, 1'b1);
        check("ackcap_valid", rx_valid, 1);
        check("ackcap_data", rx_data, 8'h7E);
        check("ackcap_ovr", ovr_cycles, exp_ovr);

        // Reset after the 4th data bit of 0xFF, then 0x00
        align(k);
        rx_serial = 1'b0;
        wait_ticks(OS);
        rx_serial = 1'b1;
        wait_ticks(4 * OS);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_valid", rx_valid, 0);
        check("midrst_data", rx_data, 0);
        check("midrst_busy", rx_busy, 0);
        check("midrst_flags", {frame_err, overrun}, 0);
        rst = 1'b1;
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        wait_ticks(20);
        align(k);
        send_frame(8'h00, 1'b1);
        model_frame(8'h00, 1'b1, 1'b0);
        wait_ticks(2);
        check("post_rst_valid", rx_valid, exp_valid);
        check("post_rst_data", rx_data, exp_data);
        check("post_rst_ferr", ferr_cycles, exp_ferr);
        check("post_rst_ovr", ovr_cycles, exp_ovr);

        // Randomized frames
        for (int n = 0; n < 12; n++) begin
            b       = 8'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) pulse_ack();
            wait_ticks($urandom_range(0, 5));
            align(k);
            send_frame(b, stop_ok);
            model_frame(b, stop_ok, 1'b0);
            wait_ticks(12);
            check("rand_data", rx_data, exp_data);
            check("rand_valid", rx_valid, exp_valid);
            check("rand_ferr", ferr_cycles, exp_ferr);
            check("rand_ovr", ovr_cycles, exp_ovr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
